aui_am_lock: RTL and testbench
==============================

# aui_am_lock

Per-lane alignment-marker lock engine for the receive side of the AUI path. It sits after the lane gearbox and before lane deskew, RS decode, descrambling and flow recombination. It searches each `LANE_WIDTH`-bit lane word for the alignment-marker pattern and requests bit slips from the gearbox until markers recur at the expected period. It then declares lock and forwards lane words, with the marker slots flagged, to the deskew stage.

## Interface
Parameters:
- `LANE_WIDTH`, 1360: lane word width in bits.
- `AM_WIDTH`, 120: marker width; the marker occupies `i_lane[AM_WIDTH-1:0]`.
- `AM_PATTERN`, `{15{8'hA5}}`: expected marker value, `AM_WIDTH` bits.
- `AM_PERIOD`, 8: valid words from one marker to the next (including the marker word). Must be ≥2.
- `AM_ERR_BITS`, 3: maximum number of mismatching bits still counted as a match.
- `AM_BAD_LIMIT`, 3: consecutive bad markers that cause loss of lock. Must be ≥1.
- `SLIP_WAIT`, 2: valid words ignored after each slip request, to let the gearbox settle.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: `i_lane` holds a new word this cycle.
- `i_lane`, in, `LANE_WIDTH`: lane word from the gearbox.
- `o_slip`, out, 1: one-cycle request to shift the gearbox by one bit.
- `o_am_lock`, out, 1: lane is locked.
- `o_valid`, out, 1: `o_lane` holds a valid word. Asserted only while locked.
- `o_lane`, out, `LANE_WIDTH`: registered copy of `i_lane`.
- `o_am_flag`, out, 1: the word on `o_lane` is a marker slot.
- `o_bad_count`, out, `$clog2(AM_BAD_LIMIT+1)`: current count of consecutive bad markers.

## Operation
- Match rule: a word matches when the popcount of `i_lane[AM_WIDTH-1:0] ^ AM_PATTERN` is ≤ `AM_ERR_BITS`. This comparison is combinational on the input word.
- `wcnt`, width `$clog2(AM_PERIOD)`: counts valid words since the last marker and wraps from `AM_PERIOD-1` to 0. The marker slot is the word seen when `wcnt == AM_PERIOD-1`.
- When `i_valid` is low, the state, `wcnt`, the wait counter and `o_bad_count` hold their values, and nothing is evaluated.
- State machine (updates only on cycles with `i_valid` high):
  - SEARCH: if the wait counter is non-zero, decrement it and ignore the word. Otherwise:
    - match: go to CONFIRM with `wcnt=0`.
    - no match: increment the search counter. When the counter reaches `AM_PERIOD` words without a match, pulse `o_slip`, clear the search counter, and load the wait counter with `SLIP_WAIT`.
  - CONFIRM: advance `wcnt`. At the marker slot:
    - match: go to LOCKED, clear `o_bad_count`, set `wcnt=0`.
    - mismatch: go to SEARCH, pulse `o_slip`, load `SLIP_WAIT`.
  - LOCKED: advance `wcnt`. At the marker slot:
    - match: clear `o_bad_count`.
    - mismatch: increment `o_bad_count`. If it reaches `AM_BAD_LIMIT`, go to SEARCH, clear `o_bad_count` and `wcnt`, pulse `o_slip`, and load `SLIP_WAIT`.
  - Non-slot words are never checked.
- Output path, registered:
  - `o_valid` is `i_valid` AND (the state is LOCKED after this update).
  - `o_am_flag` is asserted when `o_valid` is asserted and the word is the marker slot.
  - `o_lane` is updated whenever `i_valid` is high.
- The word that completes lock (the confirming marker) is emitted with `o_valid=1` and `o_am_flag=1`.
- The word that triggers loss of lock is not emitted (`o_valid=0`).

## Timing
- Reset (`rst`=0, asynchronous): state SEARCH, all counters 0. Outputs: `o_slip=0`, `o_am_lock=0`, `o_valid=0`, `o_am_flag=0`, `o_lane=0`, `o_bad_count=0`. Release is sampled on the next rising edge of `clk`.
- Reset asserted mid-operation drops lock and clears all outputs immediately (no wait for a clock edge).
- Latency is 1 cycle: the word presented with `i_valid` at edge N appears on `o_lane`/`o_valid` after edge N. `o_am_lock` and `o_slip` change after the same edge.
- `o_slip` is high for exactly one cycle per request. It never asserts on consecutive valid words, because `SLIP_WAIT` blanking follows every slip.
- Lock acquisition from the first matching marker takes `AM_PERIOD` valid words. `o_am_lock` rises after the edge that samples the confirming marker.
- `wcnt` wraps from `AM_PERIOD-1` to 0. A marker slot and an `o_bad_count` increment in the same cycle are evaluated against the pre-increment count.

## Test plan
- Aligned stream (defaults): a marker every 8 words, filler `0` → after the first marker, `o_am_lock`=1 after the 9th valid word. Thereafter `o_am_flag` is high on every 8th `o_valid` word, and `o_slip` is never asserted.
- No marker for 8 words in SEARCH → `o_slip` pulses once. The next 2 valid words are ignored, and the next slip comes 8 words later.
- Marker with 3 flipped bits → match, lock proceeds. Marker with 4 flipped bits → no match; in CONFIRM this gives SEARCH plus an `o_slip` pulse.
- While locked: corrupt 2 consecutive markers → `o_bad_count`=1, then 2, with lock kept; a good marker then resets the count to 0. Corrupt 3 consecutive markers → `o_am_lock`=0, `o_valid`=0 and an `o_slip` pulse, all after the third bad slot.
- `i_valid` toggled 1-0-1 at random while locked → `wcnt` advances only on valid words, `o_am_flag` positions are unchanged, and `o_valid` is 0 on idle cycles.
- `rst` driven low between clock edges while locked → all outputs are 0 before the next edge. After release, lock is reacquired in 8 valid words.

Source files
------------

// File: rtl/aui_am_lock_if.sv
// aui_am_lock_if: lane-word bus between the gearbox side and the AM lock engine.
//   master : drives i_valid / i_lane, observes lock engine outputs
//   slave  : the lock engine (receives lane words, drives lock/slip/output words)
// Signals:
//   i_valid      lane word qualifier
//   i_lane       lane word from the gearbox (marker in [AM_WIDTH-1:0])
//   o_slip       one-cycle bit-slip request to the gearbox
//   o_am_lock    lane is locked
//   o_valid      o_lane holds a valid word (only while locked)
//   o_lane       registered copy of i_lane
//   o_am_flag    o_lane word is a marker slot
//   o_bad_count  consecutive bad markers seen while locked
interface aui_am_lock_if #(
    parameter int unsigned LANE_WIDTH   = 1360,
    parameter int unsigned AM_BAD_LIMIT = 3
);
    localparam int unsigned BAD_W = $clog2(AM_BAD_LIMIT + 1);

    logic                  i_valid;
    logic [LANE_WIDTH-1:0] i_lane;
    logic                  o_slip;
    logic                  o_am_lock;
    logic                  o_valid;
    logic [LANE_WIDTH-1:0] o_lane;
    logic                  o_am_flag;
    logic [BAD_W-1:0]      o_bad_count;

    modport master (
        output i_valid, i_lane,
        input  o_slip, o_am_lock, o_valid, o_lane, o_am_flag, o_bad_count
    );

    modport slave (
        input  i_valid, i_lane,
        output o_slip, o_am_lock, o_valid, o_lane, o_am_flag, o_bad_count
    );
endinterface

// File: rtl/aui_am_lock.sv
// aui_am_lock: per-lane alignment-marker lock engine (AUI receive side).
// Hunts for the alignment marker in each lane word, requests gearbox bit
// slips until markers recur every AM_PERIOD valid words, then declares lock
// and forwards lane words with marker slots flagged.
// Ports:
//   clk   single clock
//   rst   asynchronous active-low reset
//   bus   aui_am_lock_if.slave (i_valid/i_lane in; o_slip, o_am_lock,
//         o_valid, o_lane, o_am_flag, o_bad_count out)
module aui_am_lock #(
    parameter int unsigned          LANE_WIDTH   = 1360,
    parameter int unsigned          AM_WIDTH     = 120,
    parameter logic [AM_WIDTH-1:0]  AM_PATTERN   = {15{8'hA5}},
    parameter int unsigned          AM_PERIOD    = 8,
    parameter int unsigned          AM_ERR_BITS  = 3,
    parameter int unsigned          AM_BAD_LIMIT = 3,
    parameter int unsigned          SLIP_WAIT    = 2
) (
    input logic          clk,
    input logic          rst,
    aui_am_lock_if.slave bus
);
    localparam int unsigned WCNT_W = $clog2(AM_PERIOD);
    localparam int unsigned WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int unsigned BAD_W  = $clog2(AM_BAD_LIMIT + 1);
    localparam int unsigned POP_W  = $clog2(AM_WIDTH + 1);

    localparam logic [WCNT_W-1:0] SLOT      = WCNT_W'(AM_PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(AM_BAD_LIMIT - 1);
    localparam logic [POP_W-1:0]  ERR_MAX   = POP_W'(AM_ERR_BITS);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    state_t                state, state_nx;
    logic [WCNT_W-1:0]     wcnt, wcnt_nx, wcnt_adv;
    logic [WCNT_W-1:0]     scnt, scnt_nx;      // unmatched words while hunting
    logic [WAIT_W-1:0]     wait_cnt, wait_nx;  // post-slip blanking
    logic [BAD_W-1:0]      bad_cnt, bad_nx;
    logic                  slip_nx;

    logic                  slip_q;
    logic                  valid_q;
    logic                  flag_q;
    logic [LANE_WIDTH-1:0] lane_q;

    logic [AM_WIDTH-1:0]   am_diff;
    logic [POP_W-1:0]      am_errs;
    logic                  am_match;
    logic                  at_slot;

    // ------------------------------------------------------------------
    // Marker match: tolerate up to AM_ERR_BITS flipped bits.
    // ------------------------------------------------------------------
    assign am_diff = bus.i_lane[AM_WIDTH-1:0] ^ AM_PATTERN;

    always_comb begin
        am_errs = '0;
        for (int unsigned i = 0; i < AM_WIDTH; i++) begin
            am_errs = am_errs + POP_W'(am_diff[i]);
        end
    end

    assign am_match = (am_errs <= ERR_MAX);
    assign at_slot  = (wcnt == SLOT);
    assign wcnt_adv = at_slot ? '0 : wcnt + WCNT_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_SEARCH;
            wcnt     <= '0;
            scnt     <= '0;
            wait_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_nx;
            wcnt     <= wcnt_nx;
            scnt     <= scnt_nx;
            wait_cnt <= wait_nx;
            bad_cnt  <= bad_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; nothing moves on idle cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        scnt_nx  = scnt;
        wait_nx  = wait_cnt;
        bad_nx   = bad_cnt;
        slip_nx  = 1'b0;

        if (bus.i_valid) begin
            case (state)
                ST_SEARCH: begin
                    if (wait_cnt != '0) begin
                        wait_nx = wait_cnt - WAIT_W'(1);
                    end else if (am_match) begin
                        state_nx = ST_CONFIRM;
                        wcnt_nx  = '0;
                        scnt_nx  = '0;
                    end else if (scnt == SLOT) begin
                        // AM_PERIOD words without a marker: try the next bit offset
                        slip_nx = 1'b1;
                        scnt_nx = '0;
                        wait_nx = WAIT_LOAD;
                    end else begin
                        scnt_nx = scnt + WCNT_W'(1);
                    end
                end

                ST_CONFIRM: begin
                    wcnt_nx = wcnt_adv;
                    if (at_slot) begin
                        if (am_match) begin
                            state_nx = ST_LOCKED;
                            bad_nx   = '0;
                        end else begin
                            state_nx = ST_SEARCH;
                            slip_nx  = 1'b1;
                            wait_nx  = WAIT_LOAD;
                            scnt_nx  = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    wcnt_nx = wcnt_adv;
                    if (at_slot) begin
                        if (am_match) begin
                            bad_nx = '0;
                        end else if (bad_cnt == BAD_LAST) begin
                            // limit reached against the pre-increment count
                            state_nx = ST_SEARCH;
                            bad_nx   = '0;
                            wcnt_nx  = '0;
                            scnt_nx  = '0;
                            slip_nx  = 1'b1;
                            wait_nx  = WAIT_LOAD;
                        end else begin
                            bad_nx = bad_cnt + BAD_W'(1);
                        end
                    end
                end

                default: begin
                    state_nx = ST_SEARCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered output path. Validity follows the post-update state so the
    // confirming marker is emitted and the lock-losing word is not.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slip_q  <= 1'b0;
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            slip_q  <= slip_nx;
            valid_q <= bus.i_valid && (state_nx == ST_LOCKED);
            flag_q  <= bus.i_valid && (state_nx == ST_LOCKED) && at_slot;
            if (bus.i_valid) begin
                lane_q <= bus.i_lane;
            end
        end
    end

    assign bus.o_slip      = slip_q;
    assign bus.o_am_lock   = (state == ST_LOCKED);
    assign bus.o_valid     = valid_q;
    assign bus.o_am_flag   = flag_q;
    assign bus.o_lane      = lane_q;
    assign bus.o_bad_count = bad_cnt;

endmodule

// File: tb/tb_aui_am_lock.sv
// tb_aui_am_lock: directed bench for aui_am_lock with a word-level model
// of the lock procedure and a per-cycle compare process.
module tb_aui_am_lock;
    localparam int unsigned LW  = 1360;
    localparam int unsigned AMW = 120;
    localparam int          P   = 8;
    localparam int          ERR = 3;
    localparam int          BL  = 3;
    localparam int          SW  = 2;
    localparam logic [AMW-1:0] PAT = {15{8'hA5}};

    logic clk;
    logic rst;

    aui_am_lock_if #(.LANE_WIDTH(LW), .AM_BAD_LIMIT(BL)) bus ();

    aui_am_lock #(
        .LANE_WIDTH  (LW),
        .AM_WIDTH    (AMW),
        .AM_PATTERN  (PAT),
        .AM_PERIOD   (P),
        .AM_ERR_BITS (ERR),
        .AM_BAD_LIMIT(BL),
        .SLIP_WAIT   (SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;
    int tag      = 1;
    int last_tag = 0;

    // model: hunting / confirming / locked, position within the marker period
    bit m_conf, m_lock;
    int m_pos, m_blank, m_miss, m_bad;
    bit e_slip, e_lock, e_valid, e_flag;
    int e_bad;
    logic [LW-1:0] e_lane;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_conf = 0; m_lock = 0;
        m_pos = 0; m_blank = 0; m_miss = 0; m_bad = 0;
        e_slip = 0; e_lock = 0; e_valid = 0; e_flag = 0; e_bad = 0;
        e_lane = '0;
    endtask

    task automatic model_slip();
        e_slip  = 1;
        m_blank = SW;
    endtask

    task automatic model(input bit v, input logic [LW-1:0] w);
        bit hit, slot;
        e_slip = 0; e_valid = 0; e_flag = 0;
        if (!v) return;
        e_lane = w;
        hit  = ($countones(w[AMW-1:0] ^ PAT) <= ERR);
        slot = (m_pos == P - 1);
        if (!m_conf && !m_lock) begin
            if (m_blank > 0) m_blank--;
            else if (hit) begin
                m_conf = 1; m_pos = 0; m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss == P) begin
                    m_miss = 0;
                    model_slip();
                end
            end
        end else begin
            m_pos = (m_pos + 1) % P;
            if (slot && hit) begin
                m_bad = 0;
                if (m_conf) begin m_conf = 0; m_lock = 1; end
            end else if (slot && m_conf) begin
                m_conf = 0;
                model_slip();
            end else if (slot) begin
                m_bad++;
                if (m_bad == BL) begin
                    m_lock = 0; m_bad = 0; m_pos = 0;
                    model_slip();
                end
            end
            e_valid = m_lock;
            e_flag  = m_lock && slot;
        end
        e_lock = m_lock;
        e_bad  = m_bad;
    endtask

    // per-cycle compare against the model, away from the active edge
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("o_slip", bus.o_slip, e_slip);
            check("o_am_lock", bus.o_am_lock, e_lock);
            check("o_valid", bus.o_valid, e_valid);
            check("o_am_flag", bus.o_am_flag, e_flag);
            check("o_bad_count", bus.o_bad_count, e_bad);
            checks++;
            if (bus.o_lane !== e_lane) begin
                failures++;
                $display("FAIL o_lane got_top=%h exp_top=%h @%0t",
                         bus.o_lane[LW-1 -: 64], e_lane[LW-1 -: 64], $time);
            end
        end
    end

    function automatic logic [LW-1:0] mk_word(input bit marker, input int flips, input int t);
        logic [LW-1:0] w;
        w = '0;
        w[LW-1 -: 32]  = 32'(t);
        w[LW-33 -: 32] = $urandom;
        if (marker) begin
            w[AMW-1:0] = PAT;
            for (int i = 0; i < flips; i++) w[i*7] = ~w[i*7];
        end
        return w;
    endfunction

    task automatic send(input bit v, input logic [LW-1:0] w);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_lane  = w;
        model(v, w);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) send(0, {43{$urandom}});
    endtask

    task automatic fill(input int n, input bit gaps = 0);
        for (int i = 0; i < n; i++) begin
            if (gaps) gap();
            last_tag = tag;
            send(1, mk_word(0, 0, tag++));
        end
    endtask

    task automatic mark(input int flips, input bit gaps = 0);
        if (gaps) gap();
        last_tag = tag;
        send(1, mk_word(1, flips, tag++));
    endtask

    task automatic period(input int flips, input bit gaps = 0);
        fill(P - 1, gaps);
        mark(flips, gaps);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_slip"}, bus.o_slip, 0);
        check({pfx, "_lock"}, bus.o_am_lock, 0);
        check({pfx, "_valid"}, bus.o_valid, 0);
        check({pfx, "_flag"}, bus.o_am_flag, 0);
        check({pfx, "_bad"}, bus.o_bad_count, 0);
        check({pfx, "_lane"}, (bus.o_lane == '0), 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_lane  = '0;
        model_reset();
        #1 rst = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1;

        // hunt: slip after 8 unmatched words, 2 blanked, next slip 8 later
        fill(8);
        settle(); check("first_slip", bus.o_slip, 1);
        fill(2);
        settle(); check("blank_no_slip", bus.o_slip, 0);
        fill(7);
        settle(); check("pre_second_slip", bus.o_slip, 0);
        fill(1);
        settle(); check("second_slip", bus.o_slip, 1);

        // acquisition: marker, 7 fillers, confirming marker
        fill(2);
        mark(0);
        settle(); check("confirm_not_locked", bus.o_am_lock, 0);
        fill(P - 1);
        settle(); check("before_confirm_lock", bus.o_am_lock, 0);
        mark(0);
        settle();
        check("lock_rise", bus.o_am_lock, 1);
        check("lock_valid", bus.o_valid, 1);
        check("lock_flag", bus.o_am_flag, 1);
        check("lock_lane_tag", bus.o_lane[LW-1 -: 32], last_tag);

        // 3 flipped bits still match
        period(3);
        settle(); check("flip3_flag", bus.o_am_flag, 1); check("flip3_bad", bus.o_bad_count, 0);
        period(3);

        // two bad markers then a good one
        period(4);
        settle(); check("bad1", bus.o_bad_count, 1); check("bad1_lock", bus.o_am_lock, 1);
        period(4);
        settle(); check("bad2", bus.o_bad_count, 2); check("bad2_lock", bus.o_am_lock, 1);
        period(0);
        settle(); check("bad_cleared", bus.o_bad_count, 0);

        // idle cycles interleaved while locked
        for (int k = 0; k < 3; k++) begin
            period(0, 1);
            settle(); check("gap_flag", bus.o_am_flag, 1);
        end

        // three bad markers lose lock
        period(4);
        period(4);
        settle(); check("loss_pre_bad", bus.o_bad_count, 2);
        period(4);
        settle();
        check("loss_lock", bus.o_am_lock, 0);
        check("loss_valid", bus.o_valid, 0);
        check("loss_slip", bus.o_slip, 1);
        check("loss_bad", bus.o_bad_count, 0);

        // confirm fails on a 4-bit-error marker
        fill(2);
        mark(0);
        fill(P - 1);
        mark(4);
        settle();
        check("confirm_fail_slip", bus.o_slip, 1);
        check("confirm_fail_lock", bus.o_am_lock, 0);

        // reacquire with a 3-bit-error confirming marker
        fill(2);
        mark(0);
        fill(P - 1);
        mark(3);
        settle(); check("relock", bus.o_am_lock, 1);
        period(0);

        // asynchronous reset between edges while locked
        @(posedge clk);
        #3;
        chk_en = 0;
        rst = 1'b0;
        bus.i_valid = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1;
        mark(0);
        fill(P - 1);
        settle(); check("post_rst_not_yet", bus.o_am_lock, 0);
        mark(0);
        settle(); check("post_rst_lock", bus.o_am_lock, 1);
        period(0);
        send(0, '0);
        settle();
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
